serial_addsub: RTL and testbench
================================

SERIAL_ADDSUB -- requirements
Module: serial_addsub

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits (>= 2).
REQ-002 SHALL have parameter DIGIT, default 1, bits processed per clock; WIDTH mod DIGIT = 0, 1 <= DIGIT <= WIDTH.
REQ-003 SHALL have clk  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have start  input  1  request new operation; sampled only when busy=0.
REQ-006 SHALL have a  input  WIDTH  operand A, sampled on accepted start.
REQ-007 SHALL have b  input  WIDTH  operand B, sampled on accepted start.
REQ-008 SHALL have op  input  1  0 = A+B, 1 = A-B (two's complement), sampled on accepted start.
REQ-009 SHALL have sum  output  WIDTH  result, registered.
REQ-010 SHALL have cout  output  1  carry out of MSB (for subtract: 1 = no borrow).
REQ-011 SHALL have ovf  output  1  signed overflow of the operation.
REQ-012 SHALL have busy  output  1  high while operation in progress.
REQ-013 SHALL have done  output  1  single-cycle pulse when sum/cout/ovf become valid.

Function
REQ-014 FSM states SHALL be IDLE, RUN, DONE; busy = (state == RUN).
REQ-015 IDLE or DONE with start=1 SHALL latch a, b, op, clear the result shift register, load carry register with op, and go to RUN.
REQ-016 start while busy=1 SHALL be ignored; latched operands unaffected.
REQ-017 Each RUN cycle SHALL process the next DIGIT bits LSB-first: digit = A_d + (B_d XOR {DIGIT{op}}) + carry; carry register <= digit carry-out.
REQ-018 RUN SHALL last exactly WIDTH/DIGIT cycles, counted by a step counter of ceil(log2(WIDTH/DIGIT+1)) bits; counter wraps to 0 on RUN exit.
REQ-019 After last RUN cycle the FSM SHALL enter DONE for exactly one cycle with done=1, then IDLE unless a new start is accepted in DONE.
REQ-020 Start accepted in DONE cycle SHALL go directly to RUN; done still pulses that cycle.
REQ-021 Latency: start accepted at edge k -> done=1 during cycle k+WIDTH/DIGIT+1.
REQ-022 cout SHALL equal final carry; ovf SHALL equal carry into MSB XOR carry out of MSB.
REQ-023 sum, cout, ovf SHALL update only on transition RUN->DONE and hold until next RUN->DONE or reset; intermediate shift-register contents SHALL not be visible on sum.
REQ-024 Outputs SHALL depend only on registers (no combinational path from inputs to outputs).

Reset
REQ-025 rst=1 SHALL immediately, independent of clk, force state IDLE, sum=0, cout=0, ovf=0, busy=0, done=0, counter/carry/shift registers 0.
REQ-026 Reset during RUN SHALL abort the operation; no done pulse SHALL follow for it.
REQ-027 First start after rst deasserts SHALL be accepted on the first rising edge where rst=0.

Configuration
REQ-028 Macro SERIAL_ADDSUB_SAT_EN defined: on ovf=1, sum SHALL be saturated to 0111..1 if the true result is positive (A MSB = 0) or 1000..0 if negative (A MSB = 1); cout and ovf reported unchanged.
REQ-029 Macro SERIAL_ADDSUB_SAT_EN undefined: sum SHALL be the wrapped WIDTH-bit result; no saturation logic synthesised.

Verification (WIDTH=8, DIGIT=1 unless stated)
REQ-030 a=8'h3C, b=8'h05, op=0, start at edge 0 -> busy cycles 1-8, done in cycle 9, sum=8'h41, cout=0, ovf=0.
REQ-031 a=8'h05, b=8'h07, op=1 -> sum=8'hFE, cout=0, ovf=0; a=8'hFF, b=8'h01, op=0 -> sum=8'h00, cout=1, ovf=0.
REQ-032 a=8'h7F, b=8'h01, op=0 -> ovf=1, cout=0, sum=8'h80 (8'h7F with SERIAL_ADDSUB_SAT_EN); a=8'h80, b=8'h01, op=1 -> ovf=1, cout=1, sum=8'h7F (8'h80 with macro).
REQ-033 start pulsed with new operands in cycle 4 of RUN -> ignored, first result unchanged; start held in DONE cycle -> back-to-back op, second done exactly 9 cycles after first.
REQ-034 rst asserted mid-RUN (cycle 4) asynchronously -> all outputs 0 immediately, no done pulse; next start yields correct result.
REQ-035 DIGIT=4: a=8'h99, b=8'h67, op=0 -> done 3 cycles after start edge, sum=8'h00, cout=1, ovf=0.

Source files
------------

// File: rtl/serial_addsub.sv
// -----------------------------------------------------------------------------
// serial_addsub
//
// Digit-serial two's complement adder/subtractor. Each operation takes
// WIDTH/DIGIT clock cycles. Every cycle it processes DIGIT bits, starting with
// the least significant digit. The carry is kept in a register between digits.
//
// Parameters
//   WIDTH  operand/result width in bits (>= 2)
//   DIGIT  bits processed per clock (1 <= DIGIT <= WIDTH, WIDTH % DIGIT == 0)
//
// Ports
//   clk    in   sole clock, rising edge
//   rst    in   asynchronous active-high reset
//   start  in   request a new operation (accepted in IDLE or DONE)
//   a, b   in   operands, captured when start is accepted
//   op     in   0 = a + b, 1 = a - b; captured when start is accepted
//   sum    out  registered result
//   cout   out  carry out of the MSB (for subtract: 1 = no borrow)
//   ovf    out  signed overflow of the operation
//   busy   out  high while the operation is running
//   done   out  one-cycle pulse when sum/cout/ovf have just been updated
//
// Configuration macro
//   SERIAL_ADDSUB_SAT_EN  when defined, an overflowing result saturates to the
//                         most positive or most negative value. The sign
//                         follows the MSB of a. cout and ovf are not changed.
// -----------------------------------------------------------------------------
module serial_addsub #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int STEPS = WIDTH / DIGIT;
  localparam int CNT_W = $clog2(STEPS + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             op_q, op_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] step_q, step_d;

  // Digit datapath. The operand registers shift right, so the current digit
  // is always in their low DIGIT bits.
  logic [DIGIT-1:0] a_dig;
  logic [DIGIT-1:0] b_dig;
  logic [DIGIT:0]   dig_sum;
  logic             dig_cout;
  logic             msb_cin;
  logic [WIDTH-1:0] res_shift;
  logic [WIDTH-1:0] fin_sum;

  assign a_dig    = a_q[DIGIT-1:0];
  assign b_dig    = b_q[DIGIT-1:0] ^ {DIGIT{op_q}};
  assign dig_sum  = {1'b0, a_dig} + {1'b0, b_dig} + {{DIGIT{1'b0}}, carry_q};
  assign dig_cout = dig_sum[DIGIT];
  // Carry into the top bit of this digit. Recover it from that bit's sum and
  // its two inputs. On the last digit, this is the carry into the word's MSB.
  assign msb_cin  = dig_sum[DIGIT-1] ^ a_dig[DIGIT-1] ^ b_dig[DIGIT-1];

  // The new digit enters at the top. After STEPS shifts, the first digit has
  // reached the LSB position.
  assign res_shift = (res_q >> DIGIT)
                   | (WIDTH'(dig_sum[DIGIT-1:0]) << (WIDTH - DIGIT));

`ifdef SERIAL_ADDSUB_SAT_EN
  always_comb begin
    fin_sum = res_shift;
    if (msb_cin ^ dig_cout) begin
      // On the last digit, a_dig[DIGIT-1] holds the MSB of a.
      fin_sum = a_dig[DIGIT-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                               : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end
`else
  assign fin_sum = res_shift;
`endif

  // Next-state and datapath control
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    carry_d = carry_q;
    res_d   = res_q;
    step_d  = step_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          op_d    = op;
          carry_d = op;     // +1 completes the two's complement of b
          res_d   = '0;
          step_d  = '0;
          state_d = RUN;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end

      RUN: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        carry_d = dig_cout;
        res_d   = res_shift;
        if (step_q == LAST_STEP) begin
          step_d  = '0;
          sum_d   = fin_sum;
          cout_d  = dig_cout;
          ovf_d   = msb_cin ^ dig_cout;
          state_d = DONE;
        end else begin
          step_d = step_q + CNT_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= 1'b0;
      carry_q <= 1'b0;
      res_q   <= '0;
      step_q  <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      carry_q <= carry_d;
      res_q   <= res_d;
      step_q  <= step_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_serial_addsub.sv
// -----------------------------------------------------------------------------
// tb_serial_addsub
//
// Testbench for serial_addsub. It uses two instances: WIDTH=8 with DIGIT=1,
// and WIDTH=8 with DIGIT=4. Each expected result {cout, ovf, sum} is pushed to
// a queue when the start is driven. It is popped and compared when done pulses.
// -----------------------------------------------------------------------------
module tb_serial_addsub;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, op;
  logic [7:0] a, b;
  logic [7:0] sum;
  logic       cout, ovf, busy, done;

  logic       start4, op4;
  logic [7:0] a4, b4;
  logic [7:0] sum4;
  logic       cout4, ovf4, busy4, done4;

  int vec_cnt = 0;
  int err_cnt = 0;

  logic [9:0] exp_q[$];   // {cout, ovf, sum} for the DIGIT=1 instance
  logic [9:0] exp4_q[$];  // same for the DIGIT=4 instance

  always #5 clk = ~clk;

  serial_addsub #(.WIDTH(8), .DIGIT(1)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .op(op),
    .sum(sum), .cout(cout), .ovf(ovf), .busy(busy), .done(done)
  );

  serial_addsub #(.WIDTH(8), .DIGIT(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .op(op4),
    .sum(sum4), .cout(cout4), .ovf(ovf4), .busy(busy4), .done(done4)
  );

  // Reference model. It computes the whole word at once and reads overflow
  // from the operand and result signs.
  function automatic logic [9:0] model(input logic [7:0] x, input logic [7:0] y,
                                       input logic o);
    logic [7:0] yy;
    logic [8:0] f;
    logic [7:0] s;
    logic       v;
    yy = o ? ~y : y;
    f  = {1'b0, x} + {1'b0, yy} + {8'b0, o};
    s  = f[7:0];
    v  = (x[7] == yy[7]) && (s[7] != x[7]);
`ifdef SERIAL_ADDSUB_SAT_EN
    if (v) s = x[7] ? 8'h80 : 8'h7F;
`endif
    return {f[8], v, s};
  endfunction

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = '0; b = '0; op = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; op4 = 1'b0;
    repeat (2) @(negedge clk);
    vec_cnt++;
    if ({sum, cout, ovf, busy, done} !== 12'h000) begin
      err_cnt++;
      $display("FAIL reset_d1 got sum=%h cout=%b ovf=%b busy=%b done=%b want all 0",
               sum, cout, ovf, busy, done);
    end
    vec_cnt++;
    if ({sum4, cout4, ovf4, busy4, done4} !== 12'h000) begin
      err_cnt++;
      $display("FAIL reset_d4 got sum=%h cout=%b ovf=%b busy=%b done=%b want all 0",
               sum4, cout4, ovf4, busy4, done4);
    end
    rst = 1'b0;
    $display("reset: outputs checked");
  endtask

  // Start at edge 0. busy must be high in cycles 1-8, done must pulse in
  // cycle 9, and sum must hold its old value until then.
  task automatic test_latency();
    logic [7:0] old_sum;
    logic [9:0] e;
    int         bad;
    old_sum = sum;
    @(posedge clk); #1;
    a = 8'h3C; b = 8'h05; op = 1'b0; start = 1'b1;
    exp_q.push_back(10'b0_0_01000001);
    @(posedge clk); #1;  // edge 0 accepted
    start = 1'b0;
    bad = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (busy !== 1'b1 || done !== 1'b0 || sum !== old_sum) bad++;
    end
    vec_cnt++;
    if (bad != 0) begin
      err_cnt++;
      $display("FAIL latency_busy got %0d bad cycles want 0", bad);
    end
    @(negedge clk);  // cycle 9
    vec_cnt++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      err_cnt++;
      $display("FAIL latency_done got done=%b busy=%b want done=1 busy=0", done, busy);
    end
    e = exp_q.pop_front();
    vec_cnt++;
    if ({cout, ovf, sum} !== e) begin
      err_cnt++;
      $display("FAIL latency_result got %h want %h", {cout, ovf, sum}, e);
    end
    @(negedge clk);
    vec_cnt++;
    if (done !== 1'b0) begin
      err_cnt++;
      $display("FAIL done_width got done=%b want 0", done);
    end
    $display("latency: 3C+05 -> sum=%h cout=%b ovf=%b", sum, cout, ovf);
  endtask

  task automatic test_vectors();
    logic [7:0] ta[10];
    logic [7:0] tbv[10];
    logic       to[10];
    logic [9:0] e;
    int         n;
    bit         got;
    ta[0] = 8'h05; tbv[0] = 8'h07; to[0] = 1'b1;
    ta[1] = 8'hFF; tbv[1] = 8'h01; to[1] = 1'b0;
    ta[2] = 8'h7F; tbv[2] = 8'h01; to[2] = 1'b0;
    ta[3] = 8'h80; tbv[3] = 8'h01; to[3] = 1'b1;
    for (int i = 4; i < 10; i++) begin
      ta[i] = 8'($urandom); tbv[i] = 8'($urandom); to[i] = 1'($urandom);
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      a = ta[i]; b = tbv[i]; op = to[i]; start = 1'b1;
      case (i)
        0: exp_q.push_back(10'b0_0_11111110);
        1: exp_q.push_back(10'b1_0_00000000);
`ifdef SERIAL_ADDSUB_SAT_EN
        2: exp_q.push_back(10'b0_1_01111111);
        3: exp_q.push_back(10'b1_1_10000000);
`else
        2: exp_q.push_back(10'b0_1_10000000);
        3: exp_q.push_back(10'b1_1_01111111);
`endif
        default: exp_q.push_back(model(ta[i], tbv[i], to[i]));
      endcase
      @(posedge clk); #1;
      start = 1'b0;
      n = 0; got = 0;
      while (!got && n < 20) begin
        @(negedge clk);
        n++;
        if (done) got = 1;
      end
      vec_cnt++;
      if (!got) begin
        err_cnt++;
        $display("FAIL vec%0d_timeout got no done want done within 20 cycles", i);
        exp_q.delete();
      end else begin
        e = exp_q.pop_front();
        if ({cout, ovf, sum} !== e || n != 9) begin
          err_cnt++;
          $display("FAIL vec%0d got {cout,ovf,sum}=%h after %0d cycles want %h after 9",
                   i, {cout, ovf, sum}, n, e);
        end
        $display("vec%0d: a=%h b=%h op=%b -> sum=%h cout=%b ovf=%b",
                 i, ta[i], tbv[i], to[i], sum, cout, ovf);
      end
    end
  endtask

  // A start pulse in RUN cycle 4 is ignored. A start held through the DONE
  // cycle launches the next operation, whose done pulse comes 9 cycles later.
  task automatic test_back_to_back();
    logic [9:0] e;
    int         n;
    @(posedge clk); #1;
    a = 8'h12; b = 8'h34; op = 1'b0; start = 1'b1;
    exp_q.push_back(model(8'h12, 8'h34, 1'b0));
    @(posedge clk); #1;  // edge 0
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;  // cycle 4
    a = 8'hAA; b = 8'h55; op = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;  // cycle 9 (DONE)
    a = 8'hC8; b = 8'h64; op = 1'b1; start = 1'b1;
    exp_q.push_back(model(8'hC8, 8'h64, 1'b1));
    @(negedge clk);
    vec_cnt++;
    e = exp_q.pop_front();
    if (done !== 1'b1 || {cout, ovf, sum} !== e) begin
      err_cnt++;
      $display("FAIL ignore_start got done=%b result=%h want done=1 result=%h",
               done, {cout, ovf, sum}, e);
    end
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    vec_cnt++;
    e = exp_q.pop_front();
    if (n != 9 || {cout, ovf, sum} !== e) begin
      err_cnt++;
      $display("FAIL back_to_back got %0d cycles result=%h want 9 cycles result=%h",
               n, {cout, ovf, sum}, e);
    end
    $display("back_to_back: second result sum=%h after %0d cycles", sum, n);
  endtask

  task automatic test_reset_mid_run();
    logic [9:0] e;
    int         n;
    int         n_bad;
    // Leave non-zero outputs so that the reset check means something.
    @(posedge clk); #1;
    a = 8'h7F; b = 8'h01; op = 1'b0; start = 1'b1;
    exp_q.push_back(model(8'h7F, 8'h01, 1'b0));
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    e = exp_q.pop_front();
    vec_cnt++;
    if ({cout, ovf, sum} !== e) begin
      err_cnt++;
      $display("FAIL pre_reset got %h want %h", {cout, ovf, sum}, e);
    end
    // Start another operation, then assert reset in the middle of cycle 4.
    @(posedge clk); #1;
    a = 8'h3C; b = 8'h05; op = 1'b0; start = 1'b1;
    exp_q.push_back(model(8'h3C, 8'h05, 1'b0));
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    vec_cnt++;
    if ({sum, cout, ovf, busy, done} !== 12'h000) begin
      err_cnt++;
      $display("FAIL async_reset got sum=%h cout=%b ovf=%b busy=%b done=%b want all 0",
               sum, cout, ovf, busy, done);
    end
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    n_bad = 0;
    repeat (12) begin
      @(negedge clk);
      if (done || busy) n_bad++;
    end
    vec_cnt++;
    if (n_bad != 0) begin
      err_cnt++;
      $display("FAIL abort_no_done got %0d active cycles want 0", n_bad);
    end
    // A start presented as reset deasserts must be accepted on the next edge.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    a = 8'h3C; b = 8'h05; op = 1'b0; start = 1'b1;
    exp_q.push_back(model(8'h3C, 8'h05, 1'b0));
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    e = exp_q.pop_front();
    vec_cnt++;
    if (n != 9 || {cout, ovf, sum} !== e) begin
      err_cnt++;
      $display("FAIL post_reset got %0d cycles result=%h want 9 cycles result=%h",
               n, {cout, ovf, sum}, e);
    end
    $display("reset_mid_run: post-reset sum=%h after %0d cycles", sum, n);
  endtask

  task automatic test_digit4();
    logic [7:0] xa[4];
    logic [7:0] xb[4];
    logic       xo[4];
    logic [9:0] e;
    int         n;
    xa[0] = 8'h99; xb[0] = 8'h67; xo[0] = 1'b0;
    xa[1] = 8'h7F; xb[1] = 8'h01; xo[1] = 1'b0;
    xa[2] = 8'h80; xb[2] = 8'h01; xo[2] = 1'b1;
    xa[3] = 8'($urandom); xb[3] = 8'($urandom); xo[3] = 1'($urandom);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      a4 = xa[i]; b4 = xb[i]; op4 = xo[i]; start4 = 1'b1;
      if (i == 0) exp4_q.push_back(10'b1_0_00000000);
      else        exp4_q.push_back(model(xa[i], xb[i], xo[i]));
      @(posedge clk); #1;
      start4 = 1'b0;
      n = 0;
      while (!done4 && n < 20) begin
        @(negedge clk);
        n++;
      end
      e = exp4_q.pop_front();
      vec_cnt++;
      if (n != 3 || {cout4, ovf4, sum4} !== e) begin
        err_cnt++;
        $display("FAIL digit4_%0d got %0d cycles result=%h want 3 cycles result=%h",
                 i, n, {cout4, ovf4, sum4}, e);
      end
      $display("digit4_%0d: a=%h b=%h op=%b -> sum=%h cout=%b ovf=%b",
               i, xa[i], xb[i], xo[i], sum4, cout4, ovf4);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got no finish want finish before 200000");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_latency();
    test_vectors();
    test_back_to_back();
    test_reset_mid_run();
    test_digit4();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
